sevenseg_scan: RTL and testbench

//  Time-multiplexed scanner for a common-pin multi-digit seven-segment display.

---
 rtl/sevenseg_scan_pkg.sv | 14 +
 rtl/sevenseg_scan_divider.sv | 47 ++++
 rtl/sevenseg_scan.sv | 114 +++++++++++
 tb/tb_sevenseg_scan.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_scan_pkg.sv
// Shared constants for the seven-segment scanner: nibble width, default geometry,
// and the digit-index width helper used by the top and the divider.
package sevenseg_scan_pkg;

  localparam int NIBBLE_W      = 4;
  localparam int DEF_DIGITS    = 4;
  localparam int DEF_DIV       = 1024;
  localparam int DEF_BLANK_CYC = 16;

  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/sevenseg_scan_divider.sv
// Slot prescaler and digit index; exposes next-state values so the top can register
// outputs that line up with the counter. No flow control, free-running from reset.
module sevenseg_scan_divider
  import sevenseg_scan_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DIV    = DEF_DIV,
  localparam int CW    = $clog2(DIV),
  localparam int IW    = idx_width(DIGITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt_nxt,
  output logic [IW-1:0] idx_nxt,
  output logic          slot_start,
  output logic          frame_end,
  output logic          frame_end_nxt
);

  logic [CW-1:0] div_cnt;
  logic [IW-1:0] idx;
  logic          cnt_wrap;

  always_comb begin
    cnt_wrap = (div_cnt == CW'(DIV - 1));
    cnt_nxt  = cnt_wrap ? '0 : div_cnt + CW'(1);
    idx_nxt  = idx;
    if (cnt_wrap) begin
      idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end
    // slot_start marks the edge into div_cnt==0; frame_end is the current boundary cycle
    slot_start    = cnt_wrap;
    frame_end     = cnt_wrap && (idx == IW'(DIGITS - 1));
    frame_end_nxt = (cnt_nxt == CW'(DIV - 1)) && (idx_nxt == IW'(DIGITS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= cnt_nxt;
      idx     <= idx_nxt;
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed seven-segment scanner with frame-aligned double-buffered loads and leading-zero blanking.
// All outputs registered and aligned to the slot counter; load is always accepted (last load wins).
module sevenseg_scan
  import sevenseg_scan_pkg::*;
#(
  parameter int DIGITS    = DEF_DIGITS,
  parameter int DIV       = DEF_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC,
  localparam int W        = NIBBLE_W * DIGITS,
  localparam int IW       = idx_width(DIGITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        value_in,
  input  logic                load,
  input  logic                lz_en,
  output logic                load_ack,
  output logic [NIBBLE_W-1:0] nibble_out,
  output logic [DIGITS-1:0]   dig_sel_n,
  output logic                blank,
  output logic                frame_tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [DIGITS-1:0] DIGIT_OFF_N = '1;

  logic [CW-1:0]     cnt_nxt;
  logic [IW-1:0]     idx_nxt;
  logic              slot_start;
  logic              frame_end;
  logic              frame_end_nxt;
  logic [W-1:0]      disp;
  logic [W-1:0]      pend;
  logic [W-1:0]      disp_nxt;
  logic              pend_vld;
  logic              commit;
  logic [DIGITS-1:0] lz_mask;
  logic              zero_above;
  logic [DIGITS-1:0] sel_n_nxt;
  logic              blank_nxt;

  sevenseg_scan_divider #(
    .DIGITS(DIGITS),
    .DIV   (DIV)
  ) u_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_nxt      (cnt_nxt),
    .idx_nxt      (idx_nxt),
    .slot_start   (slot_start),
    .frame_end    (frame_end),
    .frame_end_nxt(frame_end_nxt)
  );

  // A load arriving on the boundary cycle itself bypasses the pending buffer.
  always_comb begin
    disp_nxt = disp;
    commit   = 1'b0;
    if (frame_end) begin
      commit = load || pend_vld;
      if (load) begin
        disp_nxt = value_in;
      end else if (pend_vld) begin
        disp_nxt = pend;
      end
    end
  end

  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (disp_nxt[NIBBLE_W*k +: NIBBLE_W] == '0);
      lz_mask[k] = zero_above;
    end
  end

  always_comb begin
    blank_nxt = (int'(cnt_nxt) < BLANK_CYC) || (lz_en && lz_mask[idx_nxt]);
    sel_n_nxt = DIGIT_OFF_N;
    if (!blank_nxt) begin
      sel_n_nxt[idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp       <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
      nibble_out <= '0;
      dig_sel_n  <= DIGIT_OFF_N;
      blank      <= 1'b1;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      disp <= disp_nxt;
      if (frame_end) begin
        pend_vld <= 1'b0;
      end else if (load) begin
        pend     <= value_in;
        pend_vld <= 1'b1;
      end
      load_ack   <= commit;
      frame_tick <= frame_end_nxt;
      blank      <= blank_nxt;
      dig_sel_n  <= sel_n_nxt;
      if (slot_start) begin
        nibble_out <= disp_nxt[NIBBLE_W*int'(idx_nxt) +: NIBBLE_W];
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan at DIGITS=4, DIV=8, BLANK_CYC=2: directed sequences, a vector table
// and randomized traffic, all checked against a position-arithmetic model of the display.
module tb_sevenseg_scan;

  localparam int DIGITS    = 4;
  localparam int DIV       = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIV * DIGITS;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  vis;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value_in = '0;
  logic        load_ack;
  logic [3:0]  nibble_out;
  logic [3:0]  dig_sel_n;
  logic        blank;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int acks = 0;

  logic [15:0] m_disp, m_pend;
  bit          m_pvld, m_ack, m_lz_prev;
  logic [3:0]  s_sel, s_nib;
  logic        s_blank, s_ack, s_tick;

  sevenseg_scan #(
    .DIGITS   (DIGITS),
    .DIV      (DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value_in  (value_in),
    .load      (load),
    .lz_en     (lz_en),
    .load_ack  (load_ack),
    .nibble_out(nibble_out),
    .dig_sel_n (dig_sel_n),
    .blank     (blank),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %h, expected %h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_disp = '0; m_pend = '0; m_pvld = 0; m_ack = 0; m_lz_prev = 0; t = 0;
  endtask

  // Expected outputs derived from the cycle position within the frame.
  task automatic check_model();
    int          slot, n;
    bit          sup, bl;
    logic [15:0] sh;
    logic [3:0]  es;
    slot = (t / DIV) % DIGITS;
    n    = t % DIV;
    sh   = m_disp >> (4 * slot);
    sup  = m_lz_prev && (slot > 0) && (sh == 16'h0);
    bl   = (n < BLANK_CYC) || sup;
    es   = 4'hF;
    if (!bl) es[slot] = 1'b0;
    chk("model_blank", 16'(s_blank), 16'(bl));
    chk("model_sel", 16'(s_sel), 16'(es));
    chk("model_nibble", 16'(s_nib), 16'(sh[3:0]));
    chk("model_tick", 16'(s_tick), 16'((t % FRAME) == FRAME - 1));
    chk("model_ack", 16'(s_ack), 16'(m_ack));
  endtask

  task automatic cycle(input logic ld, input logic [15:0] v, input logic lz);
    bit bnd;
    load = ld; value_in = v; lz_en = lz;
    @(negedge clk);
    s_sel = dig_sel_n; s_nib = nibble_out; s_blank = blank; s_ack = load_ack; s_tick = frame_tick;
    acks += int'(s_ack);
    check_model();
    bnd = (t % FRAME) == FRAME - 1;
    m_lz_prev = lz;
    if (bnd) begin
      m_ack = ld || m_pvld;
      if (ld) m_disp = v;
      else if (m_pvld) m_disp = m_pend;
      m_pvld = 0;
    end else begin
      m_ack = 0;
      if (ld) begin m_pend = v; m_pvld = 1; end
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  initial begin
    vec_t        tbl[8];
    logic [3:0]  seq_a[4];
    logic [15:0] masks[5];
    logic        lz_r;
    logic [15:0] rv;
    logic [3:0]  es;

    tbl[0] = '{16'h0007, 1'b1, 4'b0001};
    tbl[1] = '{16'h0000, 1'b1, 4'b0001};
    tbl[2] = '{16'h0000, 1'b0, 4'b1111};
    tbl[3] = '{16'h00A0, 1'b1, 4'b0011};
    tbl[4] = '{16'h0B00, 1'b1, 4'b0111};
    tbl[5] = '{16'hF000, 1'b1, 4'b1111};
    tbl[6] = '{16'h1A2F, 1'b0, 4'b1111};
    tbl[7] = '{16'h0102, 1'b1, 4'b0111};
    seq_a  = '{4'hF, 4'h2, 4'hA, 4'h1};
    masks  = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

    // Reset held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sel", 16'(dig_sel_n), 16'hF);
    chk("rst_blank", 16'(blank), 16'h1);
    chk("rst_nibble", 16'(nibble_out), 16'h0);
    chk("rst_ack", 16'(load_ack), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Single load mid-frame, committed at the first boundary
    acks = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(i == 5, 16'h1A2F, 1'b0);
      if (i == 2) chk("release_sel", 16'(s_sel), 16'hE);
      if (i == 31) begin
        chk("pre_commit_nibble", 16'(s_nib), 16'h0);
        chk("boundary_tick", 16'(s_tick), 16'h1);
        chk("no_early_ack", 16'(acks), 16'h0);
      end
      if (i == 32) chk("ack_at_32", 16'(s_ack), 16'h1);
      if (i >= 32 && (i % DIV) == 4) chk("nibble_1a2f", 16'(s_nib), 16'(seq_a[(i - 32) / DIV]));
    end
    chk("ack_count_single", 16'(acks), 16'h1);

    // Two loads merged into one commit
    acks = 0;
    for (int i = 64; i < 127; i++) begin
      cycle(i == 70 || i == 80, (i == 70) ? 16'h1111 : 16'h2222, 1'b0);
      if (i == 95) chk("merge_old_nibble", 16'(s_nib), 16'h1);
      if (i == 96) begin
        chk("merge_ack", 16'(s_ack), 16'h1);
        chk("merge_nibble0", 16'(s_nib), 16'h2);
      end
      if (i == 124) chk("merge_nibble3", 16'(s_nib), 16'h2);
    end
    chk("ack_count_merge", 16'(acks), 16'h1);

    // Load exactly on the boundary cycle
    cycle(1'b1, 16'hBEEF, 1'b0);
    chk("bypass_tick", 16'(s_tick), 16'h1);
    acks = 0;
    for (int i = 128; i < 192; i++) begin
      cycle(1'b0, 16'h0, 1'b0);
      if (i == 128) begin
        chk("bypass_ack", 16'(s_ack), 16'h1);
        chk("bypass_nibble", 16'(s_nib), 16'hF);
      end
    end
    chk("ack_count_bypass", 16'(acks), 16'h1);

    // Vector table: per-slot visibility with and without leading-zero suppression
    foreach (tbl[e]) begin
      cycle(1'b1, tbl[e].value, tbl[e].lz);
      while ((t % FRAME) != 0) cycle(1'b0, 16'h0, tbl[e].lz);
      for (int j = 0; j < FRAME; j++) begin
        int k, n;
        k = (t / DIV) % DIGITS;
        n = t % DIV;
        cycle(1'b0, 16'h0, tbl[e].lz);
        if (n == 4) begin
          es = 4'hF;
          if (tbl[e].vis[k]) es[k] = 1'b0;
          chk("tbl_sel", 16'(s_sel), 16'(es));
          chk("tbl_blank", 16'(s_blank), 16'(!tbl[e].vis[k]));
          rv = tbl[e].value >> (4 * k);
          chk("tbl_nibble", 16'(s_nib), 16'(rv[3:0]));
        end
      end
    end

    // Randomized loads and lz_en changes
    lz_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) lz_r = ~lz_r;
      rv = 16'($urandom) & masks[$urandom_range(0, 4)];
      cycle($urandom_range(0, 7) == 0, rv, lz_r);
    end

    // Async reset mid-slot with a load pending
    cycle(1'b1, 16'h9876, 1'b0);
    while ((t % FRAME) != 0) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h5555, 1'b0);
    while ((t % FRAME) != 13) cycle(1'b0, 16'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_sel", 16'(dig_sel_n), 16'hF);
    chk("async_blank", 16'(blank), 16'h1);
    chk("async_nibble", 16'(nibble_out), 16'h0);
    chk("async_ack", 16'(load_ack), 16'h0);
    chk("async_tick", 16'(frame_tick), 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    acks = 0;
    for (int i = 0; i < 64; i++) cycle(1'b0, 16'h0, 1'b0);
    chk("post_reset_no_ack", 16'(acks), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
